ofifo_array: RTL and testbench

OFIFO_ARRAY -- requirements
Module: ofifo_array

---
 rtl/ofifo_array_if.sv | 38 +++
 rtl/ofifo_array.sv | 144 ++++++++++++++
 tb/tb_ofifo_array.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ofifo_array_if.sv
// rtl/ofifo_array_if.sv - data/handshake/status bundle for the ofifo_array column FIFO block
//
// Parameters: col (columns), bw (bits per column).
// Signals:
//   in[col*bw], wr[col], rd                    - producer/consumer requests into the block
//   out[col*bw], o_out_valid                   - registered read data and its valid flag
//   o_full, o_ready, o_valid, o_almost_full,
//   o_empty_vec[col], o_err_ovf, o_err_udf     - status and sticky error flags
// Modports: master drives requests and observes status; slave is the FIFO block.
interface ofifo_array_if #(
  parameter int col = 8,
  parameter int bw  = 16
);
  logic [col*bw-1:0] in;
  logic [col-1:0]    wr;
  logic              rd;
  logic [col*bw-1:0] out;
  logic              o_out_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_valid;
  logic              o_almost_full;
  logic [col-1:0]    o_empty_vec;
  logic              o_err_ovf;
  logic              o_err_udf;

  modport master (
    output in, wr, rd,
    input  out, o_out_valid, o_full, o_ready, o_valid, o_almost_full,
           o_empty_vec, o_err_ovf, o_err_udf
  );

  modport slave (
    input  in, wr, rd,
    output out, o_out_valid, o_full, o_ready, o_valid, o_almost_full,
           o_empty_vec, o_err_ovf, o_err_udf
  );
endinterface

// File: rtl/ofifo_array.sv
// rtl/ofifo_array.sv - array of per-column circular FIFOs with an aligned, delayed read of all columns
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-low reset
//   bus   - ofifo_array_if.slave: in/wr per-column writes, rd aligned read request,
//           out/o_out_valid registered read data, status flags, sticky error flags
// Parameters: col, bw, depth (power of two, >= 4), rd_lat (0..3), af_margin (1..depth-1).
// Optional feature macro: OFIFO_ARRAY_ERR_EN enables the sticky overflow/underflow flags;
// when undefined, o_err_ovf/o_err_udf are tied to 0 and no flag registers exist.
module ofifo_array #(
  parameter int col       = 8,
  parameter int bw        = 16,
  parameter int depth     = 64,
  parameter int rd_lat    = 2,
  parameter int af_margin = 4
) (
  input logic         clk,
  input logic         reset,
  ofifo_array_if.slave bus
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] cnt_full = cw'(depth);
  localparam logic [cw-1:0] cnt_af   = cw'(depth - af_margin);

  logic [bw-1:0]     mem [col][depth];
  logic [aw-1:0]     wp  [col];
  logic [aw-1:0]     rp  [col];
  logic [cw-1:0]     cnt [col];

  logic [col-1:0]    empty_vec;
  logic [col-1:0]    full_vec;
  logic [col-1:0]    af_vec;
  logic [col-1:0]    wr_ok;
  logic [col*bw-1:0] head;
  logic [col*bw-1:0] out_q;
  logic              out_valid_q;
  logic              rd_eff;
  logic              pop;

  // Read request delay line; rd_lat=0 uses rd directly.
  generate
    if (rd_lat == 0) begin : g_rd_direct
      assign rd_eff = bus.rd;
    end else if (rd_lat == 1) begin : g_rd_one
      logic rd_pipe;
      always_ff @(posedge clk) begin
        if (!reset) rd_pipe <= 1'b0;
        else        rd_pipe <= bus.rd;
      end
      assign rd_eff = rd_pipe;
    end else begin : g_rd_multi
      logic [rd_lat-1:0] rd_pipe;
      always_ff @(posedge clk) begin
        if (!reset) rd_pipe <= '0;
        else        rd_pipe <= {rd_pipe[rd_lat-2:0], bus.rd};
      end
      assign rd_eff = rd_pipe[rd_lat-1];
    end
  endgenerate

  always_comb begin
    empty_vec = '0;
    full_vec  = '0;
    af_vec    = '0;
    head      = '0;
    for (int i = 0; i < col; i++) begin
      empty_vec[i]       = (cnt[i] == '0);
      full_vec[i]        = (cnt[i] == cnt_full);
      af_vec[i]          = (cnt[i] >= cnt_af);
      head[i*bw +: bw]   = mem[i][rp[i]];
    end
  end

  // A pop needs every column populated; a full column may still take a write
  // when the pop frees its head slot at the same edge.
  assign pop   = rd_eff & ~|empty_vec;
  assign wr_ok = bus.wr & (~full_vec | {col{pop}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pop;
      if (pop) out_q <= head;
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) wp[i] <= wp[i] + aw'(1);
        if (pop)      rp[i] <= rp[i] + aw'(1);
        case ({wr_ok[i], pop})
          2'b10:   cnt[i] <= cnt[i] + cw'(1);
          2'b01:   cnt[i] <= cnt[i] - cw'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Storage is not cleared by reset; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) mem[i][wp[i]] <= bus.in[i*bw +: bw];
      end
    end
  end

  assign bus.out           = out_q;
  assign bus.o_out_valid   = out_valid_q;
  assign bus.o_full        = |full_vec;
  assign bus.o_ready       = ~|full_vec;
  assign bus.o_valid       = ~|empty_vec;
  assign bus.o_almost_full = |af_vec;
  assign bus.o_empty_vec   = empty_vec;

`ifdef OFIFO_ARRAY_ERR_EN
  logic err_ovf_q;
  logic err_udf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (|(bus.wr & full_vec & ~{col{pop}})) err_ovf_q <= 1'b1;
      if (rd_eff && |empty_vec)               err_udf_q <= 1'b1;
    end
  end

  assign bus.o_err_ovf = err_ovf_q;
  assign bus.o_err_udf = err_udf_q;
`else
  assign bus.o_err_ovf = 1'b0;
  assign bus.o_err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo_array.sv
// tb/tb_ofifo_array.sv - directed self-checking bench for ofifo_array (col=4, bw=8, depth=8, rd_lat=2)
module tb_ofifo_array;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic exp_err;

  ofifo_array_if #(.col(4), .bw(8)) bus ();

  ofifo_array #(.col(4), .bw(8), .depth(8), .rd_lat(2), .af_margin(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Pulses rd for one cycle and waits (bounded) for o_out_valid; lat=0 means it never came.
  task automatic read_pulse(output int lat, output logic [31:0] data);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    lat  = 0;
    data = '0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.o_out_valid) begin
        lat  = k;
        data = bus.out;
        break;
      end
      if (k < 6) tick();
    end
  endtask

  task automatic test_reset;
    bus.in = '0;
    do_reset();
    n_cmp++; if (bus.o_empty_vec !== 4'b1111) begin n_bad++; $display("FAIL rst_empty_vec got %b want 1111", bus.o_empty_vec); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_full !== 1'b0 || bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_full_ready got %b%b want 01", bus.o_full, bus.o_ready); end
    n_cmp++; if (bus.o_almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_almost_full got %b want 0", bus.o_almost_full); end
    n_cmp++; if (bus.o_out_valid !== 1'b0 || bus.out !== 32'h0) begin n_bad++; $display("FAIL rst_out got %b/%h want 0/00000000", bus.o_out_valid, bus.out); end
    n_cmp++; if (bus.o_err_ovf !== 1'b0 || bus.o_err_udf !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b%b want 00", bus.o_err_ovf, bus.o_err_udf); end
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] d;
    do_reset();
    bus.wr = 4'hF; bus.in = 32'h11111111; tick();
    bus.in = 32'h22222222; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", bus.o_valid); end
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1 got %b want 0", bus.o_out_valid); end
    tick();
    n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat2 got %b want 0", bus.o_out_valid); end
    tick();
    n_cmp++; if (bus.o_out_valid !== 1'b1 || bus.out !== 32'h11111111) begin n_bad++; $display("FAIL basic_pop1 got %b/%h want 1/11111111", bus.o_out_valid, bus.out); end
    tick();
    n_cmp++; if (bus.o_out_valid !== 1'b0 || bus.out !== 32'h11111111) begin n_bad++; $display("FAIL basic_hold got %b/%h want 0/11111111", bus.o_out_valid, bus.out); end
    read_pulse(lat, d);
    n_cmp++; if (lat !== 3 || d !== 32'h22222222) begin n_bad++; $display("FAIL basic_pop2 got lat %0d data %h want lat 3 data 22222222", lat, d); end
    n_cmp++; if (bus.o_empty_vec !== 4'b1111) begin n_bad++; $display("FAIL basic_drained got %b want 1111", bus.o_empty_vec); end
  endtask

  task automatic test_full_and_bypass;
    int lat;
    logic [31:0] d;
    do_reset();
    bus.wr = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      bus.in = {24'h0, 8'(i)};
      tick();
      if (i == 6) begin
        n_cmp++; if (bus.o_full !== 1'b0) begin n_bad++; $display("FAIL full_at7 got %b want 0", bus.o_full); end
      end
    end
    n_cmp++; if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL full_at8 got %b%b want 10", bus.o_full, bus.o_ready); end
    n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_empty_vec !== 4'b1110) begin n_bad++; $display("FAIL full_valid got %b/%b want 0/1110", bus.o_valid, bus.o_empty_vec); end
    bus.in = 32'h000000EE; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_err_ovf !== exp_err || bus.o_full !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b/%b want %b/1", bus.o_err_ovf, bus.o_full, exp_err); end
    bus.wr = 4'b1110; bus.in = 32'h33333300; tick();
    bus.in = 32'h44444400; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid got %b want 1", bus.o_valid); end
    bus.rd = 1'b1; tick(); bus.rd = 1'b0; tick();
    bus.wr = 4'b0001; bus.in = 32'h000000F0; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_out_valid !== 1'b1 || bus.out !== 32'h33333300) begin n_bad++; $display("FAIL bypass_pop got %b/%h want 1/33333300", bus.o_out_valid, bus.out); end
    n_cmp++; if (bus.o_full !== 1'b1) begin n_bad++; $display("FAIL bypass_count got full %b want 1", bus.o_full); end
    read_pulse(lat, d);
    n_cmp++; if (lat !== 3 || d !== 32'h44444401) begin n_bad++; $display("FAIL bypass_pop2 got lat %0d data %h want lat 3 data 44444401", lat, d); end
    n_cmp++; if (bus.o_full !== 1'b0 || bus.o_empty_vec !== 4'b1110) begin n_bad++; $display("FAIL bypass_after got %b/%b want 0/1110", bus.o_full, bus.o_empty_vec); end
  endtask

  task automatic test_underflow;
    int lat;
    logic [31:0] d;
    do_reset();
    bus.wr = 4'b1011; bus.in = 32'h55555555; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_empty_vec !== 4'b0100 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL udf_setup got %b/%b want 0100/0", bus.o_empty_vec, bus.o_valid); end
    bus.rd = 1'b1; tick(); bus.rd = 1'b0; tick();
    // Column 2 is written in the very cycle the delayed read arrives: it must not pop.
    bus.wr = 4'b0100; bus.in = 32'h00660000; tick();
    bus.wr = '0;
    n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL udf_nopop got %b want 0", bus.o_out_valid); end
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_empty_vec !== 4'b0000) begin n_bad++; $display("FAIL udf_visible got %b/%b want 1/0000", bus.o_valid, bus.o_empty_vec); end
    tick();
    n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL udf_nopop2 got %b want 0", bus.o_out_valid); end
    n_cmp++; if (bus.o_err_udf !== exp_err) begin n_bad++; $display("FAIL udf_flag got %b want %b", bus.o_err_udf, exp_err); end
    read_pulse(lat, d);
    n_cmp++; if (lat !== 3 || d !== 32'h55665555) begin n_bad++; $display("FAIL udf_pop got lat %0d data %h want lat 3 data 55665555", lat, d); end
    n_cmp++; if (bus.o_empty_vec !== 4'b1111) begin n_bad++; $display("FAIL udf_drained got %b want 1111", bus.o_empty_vec); end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    logic [7:0] v;
    logic [7:0] e;
    int lat;
    logic [31:0] d;
    do_reset();
    v = 8'h10;
    for (int i = 0; i < 4; i++) begin
      bus.wr = 4'hF; bus.in = {4{v}}; tick();
      q.push_back(v); v = v + 8'h1;
      if (i == 2) begin
        n_cmp++; if (bus.o_almost_full !== 1'b0) begin n_bad++; $display("FAIL af_at3 got %b want 0", bus.o_almost_full); end
      end
    end
    bus.wr = '0;
    n_cmp++; if (bus.o_almost_full !== 1'b1) begin n_bad++; $display("FAIL af_at4 got %b want 1", bus.o_almost_full); end
    for (int k = 0; k < 16; k++) begin
      bus.wr = 4'hF; bus.in = {4{v}}; tick();
      bus.wr = '0;
      q.push_back(v); v = v + 8'h1;
      read_pulse(lat, d);
      e = q.pop_front();
      n_cmp++; if (lat !== 3 || d !== {4{e}}) begin n_bad++; $display("FAIL wrap_order[%0d] got lat %0d data %h want lat 3 data %h", k, lat, d, {4{e}}); end
    end
    n_cmp++; if (bus.o_almost_full !== 1'b1) begin n_bad++; $display("FAIL af_before_drain got %b want 1", bus.o_almost_full); end
    for (int k = 0; k < 4; k++) begin
      read_pulse(lat, d);
      e = q.pop_front();
      n_cmp++; if (lat !== 3 || d !== {4{e}}) begin n_bad++; $display("FAIL drain_order[%0d] got lat %0d data %h want lat 3 data %h", k, lat, d, {4{e}}); end
      if (k == 0) begin
        n_cmp++; if (bus.o_almost_full !== 1'b0) begin n_bad++; $display("FAIL af_at3_drain got %b want 0", bus.o_almost_full); end
      end
    end
    n_cmp++; if (bus.o_empty_vec !== 4'b1111) begin n_bad++; $display("FAIL wrap_drained got %b want 1111", bus.o_empty_vec); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    logic [31:0] d;
    do_reset();
    bus.wr = 4'hF; bus.in = 32'h77777777; tick();
    bus.wr = '0;
    read_pulse(lat, d);
    n_cmp++; if (d !== 32'h77777777) begin n_bad++; $display("FAIL mid_pre got %h want 77777777", d); end
    bus.wr = 4'hF;
    for (int i = 0; i < 5; i++) begin bus.in = {4{8'(8'h80 + i)}}; tick(); end
    bus.wr = '0;
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    n_cmp++; if (bus.o_empty_vec !== 4'b1111 || bus.out !== 32'h0 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_cleared got %b/%h/%b want 1111/00000000/0", bus.o_empty_vec, bus.out, bus.o_valid); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0 || bus.out !== 32'h0) begin n_bad++; $display("FAIL mid_no_pop got %0d valid cycles out %h want 0 / 00000000", seen, bus.out); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef OFIFO_ARRAY_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_and_bypass();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
